// File: rtl/serial_arith_pkg.sv
// -----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the LSB-first serial arithmetic blocks.
//   state_t   : word-tracking state (IDLE, CARRY, COMP)
//   MODE_PASS : word is forwarded unchanged
//   MODE_NEG  : word is two's-complement negated
// -----------------------------------------------------------------------------
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // between words
    CARRY = 2'd1,  // in a word, all digits so far zero: +1 still pending
    COMP  = 2'd2   // in a word, +1 already absorbed: plain complement
  } state_t;

  localparam logic MODE_PASS = 1'b0;
  localparam logic MODE_NEG  = 1'b1;

endpackage

// File: rtl/serial_twos_negator_if.sv
// -----------------------------------------------------------------------------
// serial_twos_negator_if
// Framed digit stream in, framed digit stream out, plus status.
//   master : producer/consumer side (drives input stream, out_ready)
//   slave  : the negator (drives in_ready, output stream, out_ovf, err)
// -----------------------------------------------------------------------------
interface serial_twos_negator_if #(
  parameter int DIGIT_W = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [DIGIT_W-1:0] in_digit;
  logic               in_sop;
  logic               in_eop;
  logic               neg_en;
  logic               out_valid;
  logic               out_ready;
  logic [DIGIT_W-1:0] out_digit;
  logic               out_sop;
  logic               out_eop;
  logic               out_ovf;
  logic               err;

  modport master (
    output in_valid, in_digit, in_sop, in_eop, neg_en, out_ready,
    input  in_ready, out_valid, out_digit, out_sop, out_eop, out_ovf, err
  );

  modport slave (
    input  in_valid, in_digit, in_sop, in_eop, neg_en, out_ready,
    output in_ready, out_valid, out_digit, out_sop, out_eop, out_ovf, err
  );

endinterface

// File: rtl/serial_digit_neg.sv
// -----------------------------------------------------------------------------
// serial_digit_neg
// Combinational per-digit negate/pass slice.
//   i_x         : input digit
//   i_c         : pending +1 carry into this digit
//   i_mode      : MODE_NEG or MODE_PASS
//   o_y         : result digit
//   o_x_nonzero : input digit is nonzero (the +1 has been absorbed)
//   o_x_msb     : msb of the input digit
//   o_y_msb     : msb of the result digit
// -----------------------------------------------------------------------------
module serial_digit_neg
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] i_x,
  input  logic               i_c,
  input  logic               i_mode,
  output logic [DIGIT_W-1:0] o_y,
  output logic               o_x_nonzero,
  output logic               o_x_msb,
  output logic               o_y_msb
);

  logic [DIGIT_W-1:0] w_neg;

  // The carry-out of ~x + c is set only when x==0 and c==1, which the FSM
  // already tracks through o_x_nonzero, so it is not kept here.
  assign w_neg       = ~i_x + DIGIT_W'(i_c);
  assign o_y         = (i_mode == MODE_NEG) ? w_neg : i_x;
  assign o_x_nonzero = |i_x;
  assign o_x_msb     = i_x[DIGIT_W-1];
  assign o_y_msb     = o_y[DIGIT_W-1];

endmodule

// File: rtl/serial_twos_negator.sv
// -----------------------------------------------------------------------------
// serial_twos_negator
// Negates or forwards LSB-first serial words, DIGIT_W bits per beat, with one
// registered output stage and a valid/ready handshake on both sides.
//   clk    : clock, rising edge
//   areset : asynchronous active-high reset
//   bus    : slave modport of serial_twos_negator_if
//            in_valid/in_ready/in_digit/in_sop/in_eop/neg_en    (input stream)
//            out_valid/out_ready/out_digit/out_sop/out_eop      (output stream)
//            out_ovf : with out_eop, word was the most-negative value
//            err     : one-cycle pulse on an orphan digit or aborted word
// -----------------------------------------------------------------------------
module serial_twos_negator
  import serial_arith_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic                        clk,
  input  logic                        areset,
  serial_twos_negator_if.slave        bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_mode;

  logic               r_vld_p1;
  logic [DIGIT_W-1:0] r_digit_p1;
  logic               r_sop_p1;
  logic               r_eop_p1;
  logic               r_ovf_p1;
  logic               r_err_p1;

  logic               w_in_ready;
  logic               w_acc;
  logic               w_load;
  logic               w_orphan;
  logic               w_abort;
  logic               w_c;
  logic               w_mode;
  logic [DIGIT_W-1:0] w_y;
  logic               w_x_nonzero;
  logic               w_x_msb;
  logic               w_y_msb;
  logic               w_ovf;

  // Single output stage: accept whenever the register is empty or draining.
  assign w_in_ready = ~r_vld_p1 | bus.out_ready;
  assign w_acc      = bus.in_valid & w_in_ready;

  // sop always starts a fresh word with the +1 pending and a new mode.
  assign w_c    = bus.in_sop | (r_state == CARRY);
  assign w_mode = bus.in_sop ? bus.neg_en : r_mode;

  serial_digit_neg #(
    .DIGIT_W (DIGIT_W)
  ) u_digit (
    .i_x         (bus.in_digit),
    .i_c         (w_c),
    .i_mode      (w_mode),
    .o_y         (w_y),
    .o_x_nonzero (w_x_nonzero),
    .o_x_msb     (w_x_msb),
    .o_y_msb     (w_y_msb)
  );

  // ~x + 1 keeps the msb set only for x = 100..0, i.e. the most-negative word.
  assign w_ovf = bus.in_eop & (w_mode == MODE_NEG) & w_x_msb & w_y_msb;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_orphan    = 1'b0;
    w_abort     = 1'b0;
    if (w_acc) begin
      if (bus.in_sop) begin
        w_load  = 1'b1;
        w_abort = (r_state != IDLE);
      end else if (r_state == IDLE) begin
        w_orphan = 1'b1;
      end else begin
        w_load = 1'b1;
      end
      if (w_load) begin
        if (bus.in_eop) begin
          w_state_nxt = IDLE;
        end else if (w_c && !w_x_nonzero) begin
          w_state_nxt = CARRY;
        end else begin
          w_state_nxt = COMP;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
      r_mode  <= MODE_PASS;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc && bus.in_sop) begin
        r_mode <= bus.neg_en;
      end
    end
  end

  // ---- stage p1: registered output beat ----
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_vld_p1   <= 1'b0;
      r_digit_p1 <= '0;
      r_sop_p1   <= 1'b0;
      r_eop_p1   <= 1'b0;
      r_ovf_p1   <= 1'b0;
      r_err_p1   <= 1'b0;
    end else begin
      r_err_p1 <= w_orphan | w_abort;
      if (w_load) begin
        r_vld_p1   <= 1'b1;
        r_digit_p1 <= w_y;
        r_sop_p1   <= bus.in_sop;
        r_eop_p1   <= bus.in_eop;
        r_ovf_p1   <= w_ovf;
      end else if (bus.out_ready) begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_p1;
  assign bus.out_digit = r_digit_p1;
  assign bus.out_sop   = r_sop_p1;
  assign bus.out_eop   = r_eop_p1;
  assign bus.out_ovf   = r_ovf_p1;
  assign bus.err       = r_err_p1;

endmodule

// File: tb/tb_serial_twos_negator.sv
// -----------------------------------------------------------------------------
// tb_serial_twos_negator
// Directed and randomized checks of serial_twos_negator at DIGIT_W=4 and 1.
// Expected results come from whole-word arithmetic: the negated word is
// (2^W - v) mod 2^W, split into digits LSB-first.
// -----------------------------------------------------------------------------
module tb_serial_twos_negator;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  serial_twos_negator_if #(.DIGIT_W(4)) bus4();
  serial_twos_negator_if #(.DIGIT_W(1)) bus1();

  serial_twos_negator #(.DIGIT_W(4)) dut4 (.clk(clk), .areset(areset), .bus(bus4));
  serial_twos_negator #(.DIGIT_W(1)) dut1 (.clk(clk), .areset(areset), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one digit into the 4-bit DUT, check the beat one cycle later, then
  // optionally hold out_ready low for 'stall' cycles and check it stays put.
  task automatic send4(input string tag, input logic [3:0] d, input logic sop,
                       input logic eop, input logic neg, input logic [3:0] ed,
                       input logic esop, input logic eeop, input logic eovf,
                       input logic eerr, input int stall);
    bus4.in_valid  = 1'b1;
    bus4.in_digit  = d;
    bus4.in_sop    = sop;
    bus4.in_eop    = eop;
    bus4.neg_en    = neg;
    bus4.out_ready = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    check({tag, ".vld"}, bus4.out_valid, 1);
    check({tag, ".dig"}, bus4.out_digit, ed);
    check({tag, ".sop"}, bus4.out_sop, esop);
    check({tag, ".eop"}, bus4.out_eop, eeop);
    if (eeop) check({tag, ".ovf"}, bus4.out_ovf, eovf);
    check({tag, ".err"}, bus4.err, eerr);
    for (int i = 0; i < stall; i++) begin
      bus4.out_ready = 1'b0;
      bus4.in_valid  = 1'b1;
      bus4.in_digit  = ~d;
      bus4.in_sop    = 1'b0;
      bus4.in_eop    = 1'b0;
      #1;
      check({tag, ".stall_rdy"}, bus4.in_ready, 0);
      step();
      check({tag, ".stall_vld"}, bus4.out_valid, 1);
      check({tag, ".stall_dig"}, bus4.out_digit, ed);
      check({tag, ".stall_eop"}, bus4.out_eop, eeop);
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
  endtask

  task automatic idle4(input string tag);
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    step();
    check({tag, ".idle_vld"}, bus4.out_valid, 0);
  endtask

  task automatic send1(input string tag, input logic d, input logic sop,
                       input logic eop, input logic neg, input logic ed,
                       input logic eovf);
    bus1.in_valid  = 1'b1;
    bus1.in_digit  = d;
    bus1.in_sop    = sop;
    bus1.in_eop    = eop;
    bus1.neg_en    = neg;
    bus1.out_ready = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    check({tag, ".vld"}, bus1.out_valid, 1);
    check({tag, ".dig"}, bus1.out_digit, ed);
    check({tag, ".sop"}, bus1.out_sop, sop);
    check({tag, ".eop"}, bus1.out_eop, eop);
    if (eop) check({tag, ".ovf"}, bus1.out_ovf, eovf);
    check({tag, ".err"}, bus1.err, 0);
  endtask

  initial begin
    int unsigned    len;
    longint unsigned mask, v, r;
    logic           neg, ovf, dneg;
    logic [3:0]     d, ed;
    int             stall;
    logic [3:0]     bits [4];

    areset = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_digit = '0; bus4.in_sop = 1'b0;
    bus4.in_eop = 1'b0; bus4.neg_en = 1'b0; bus4.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_digit = '0; bus1.in_sop = 1'b0;
    bus1.in_eop = 1'b0; bus1.neg_en = 1'b0; bus1.out_ready = 1'b1;
    step();
    step();

    // Reset state
    check("rst.vld4", bus4.out_valid, 0);
    check("rst.dig4", bus4.out_digit, 0);
    check("rst.sop4", bus4.out_sop, 0);
    check("rst.eop4", bus4.out_eop, 0);
    check("rst.ovf4", bus4.out_ovf, 0);
    check("rst.err4", bus4.err, 0);
    check("rst.rdy4", bus4.in_ready, 1);
    check("rst.vld1", bus1.out_valid, 0);
    areset = 1'b0;
    step();

    // Negate 0x0C -> 0xF4, back to back
    send4("n0C_0", 4'hC, 1, 0, 1, 4'h4, 1, 0, 0, 0, 0);
    send4("n0C_1", 4'h0, 0, 1, 1, 4'hF, 0, 1, 0, 0, 0);
    idle4("n0C");

    // Most-negative 0x80 overflows; 0x00 does not
    send4("n80_0", 4'h0, 1, 0, 1, 4'h0, 1, 0, 0, 0, 0);
    send4("n80_1", 4'h8, 0, 1, 1, 4'h8, 0, 1, 1, 0, 0);
    send4("n00_0", 4'h0, 1, 0, 1, 4'h0, 1, 0, 0, 0, 0);
    send4("n00_1", 4'h0, 0, 1, 1, 4'h0, 0, 1, 0, 0, 0);
    idle4("n00");

    // Pass mode latched at sop; neg_en flip mid-word ignored
    send4("p5A_0", 4'hA, 1, 0, 0, 4'hA, 1, 0, 0, 0, 0);
    send4("p5A_1", 4'h5, 0, 1, 1, 4'h5, 0, 1, 0, 0, 0);
    idle4("p5A");

    // Backpressure for 3 cycles mid-word
    send4("bp_0", 4'hC, 1, 0, 1, 4'h4, 1, 0, 0, 0, 3);
    send4("bp_1", 4'h0, 0, 1, 1, 4'hF, 0, 1, 0, 0, 0);
    idle4("bp");

    // Orphan digit in IDLE: dropped, err pulse
    bus4.in_valid = 1'b1; bus4.in_digit = 4'h3;
    bus4.in_sop = 1'b0; bus4.in_eop = 1'b0; bus4.neg_en = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    check("orph.vld", bus4.out_valid, 0);
    check("orph.err", bus4.err, 1);
    step();
    check("orph.err_clr", bus4.err, 0);
    check("orph.vld2", bus4.out_valid, 0);

    // sop during a word: abort, err pulse, new word starts with c=1
    send4("ab_0", 4'h3, 1, 0, 1, 4'hD, 1, 0, 0, 0, 0);
    send4("ab_1", 4'hC, 1, 0, 1, 4'h4, 1, 0, 0, 1, 0);
    send4("ab_2", 4'h0, 0, 1, 1, 4'hF, 0, 1, 0, 0, 0);
    idle4("ab");

    // Randomized words against whole-word arithmetic
    for (int w = 0; w < 40; w++) begin
      len  = $urandom_range(1, 8);
      mask = (64'd1 << (4 * len)) - 64'd1;
      v    = {$urandom, $urandom} & mask;
      if (w % 8 == 3) v = 64'd1 << (4 * len - 1);
      if (w % 8 == 5) v = 64'd0;
      neg  = 1'($urandom % 2);
      r    = neg ? ((~v + 64'd1) & mask) : v;
      ovf  = neg && (v == (64'd1 << (4 * len - 1)));
      for (int i = 0; i < int'(len); i++) begin
        d     = 4'(v >> (4 * i));
        ed    = 4'(r >> (4 * i));
        dneg  = (i == 0) ? neg : 1'($urandom % 2);
        stall = ($urandom % 5 == 0) ? int'($urandom_range(1, 3)) : 0;
        send4($sformatf("rnd%0d_%0d", w, i), d, i == 0, i == int'(len) - 1,
              dneg, ed, i == 0, i == int'(len) - 1, ovf, 0, stall);
      end
      if ($urandom % 3 == 0) idle4($sformatf("rnd%0d", w));
    end
    idle4("rnd_end");

    // DIGIT_W=1: 0b1100 negated is 0b0100
    bits[0] = 4'd0; bits[1] = 4'd0; bits[2] = 4'd1; bits[3] = 4'd0;
    send1("b1_0", 1'b0, 1, 0, 1, bits[0][0], 0);
    send1("b1_1", 1'b0, 0, 0, 1, bits[1][0], 0);
    send1("b1_2", 1'b1, 0, 0, 1, bits[2][0], 0);
    send1("b1_3", 1'b1, 0, 1, 1, bits[3][0], 0);
    bus1.in_valid = 1'b0;
    step();
    check("b1.idle_vld", bus1.out_valid, 0);

    // Reset mid-word clears the output register immediately
    send1("rm_0", 1'b1, 1, 0, 1, 1'b1, 0);
    areset = 1'b1;
    #1;
    check("rm.vld", bus1.out_valid, 0);
    check("rm.dig", bus1.out_digit, 0);
    step();
    areset = 1'b0;
    step();
    check("rm.vld2", bus1.out_valid, 0);
    // 3-bit word 001 negated is 111; err must stay low (no stale word)
    send1("rw_0", 1'b1, 1, 0, 1, 1'b1, 0);
    send1("rw_1", 1'b0, 0, 0, 1, 1'b1, 0);
    send1("rw_2", 1'b0, 0, 1, 1, 1'b1, 0);
    bus1.in_valid = 1'b0;
    step();
    check("rw.idle_vld", bus1.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_twos_negator.md
Name: serial_twos_negator

Overview:
- Parametrised successor to the single-bit serial complementer FSM. Negates (two's complement) or passes through LSB-first serial words, DIGIT_W bits per cycle.
- Words arrive as framed digit streams (sop/eop) with a valid/ready handshake and one registered output stage (Moore-style: outputs come only from registers).
- Reports negation overflow (most-negative input) and framing errors.
- Sits between serial arithmetic producers and consumers in the datapath.

Parameters:
- DIGIT_W, 4, bits per digit (per accepted beat); must be >= 1; DIGIT_W=1 reproduces bit-serial behaviour.

Ports:
- clk  input  1  system clock, rising edge
- areset  input  1  asynchronous, active-high reset
- in_valid  input  1  input digit valid
- in_ready  output  1  block can accept a digit this cycle
- in_digit  input  DIGIT_W  input digit, LSB-first within the word
- in_sop  input  1  first digit of word
- in_eop  input  1  last digit of word
- neg_en  input  1  1 = negate word, 0 = pass through; sampled only on the accepted sop digit
- out_valid  output  1  output digit valid
- out_ready  input  1  downstream accepts output digit
- out_digit  output  DIGIT_W  result digit
- out_sop  output  1  first digit of result word
- out_eop  output  1  last digit of result word
- out_ovf  output  1  valid only with out_eop: negation overflowed
- err  output  1  one-cycle pulse on a framing error

Behaviour:
- Clock and reset: one clock (clk); reset (areset) is asynchronous and active-high.
- Reset: state=IDLE, mode=0, out_valid=0, out_digit=0, out_sop=0, out_eop=0, out_ovf=0, err=0. Reset mid-word discards the word and clears the output register.
- Handshake:
  - Input accept = in_valid & in_ready.
  - in_ready = ~out_valid | out_ready (single stage, combinational ready path).
  - An output beat is consumed when out_valid & out_ready.
  - out_valid rises the cycle after an accepted digit and holds, with all out_* fields stable, until consumed.
  - Latency is exactly 1 cycle; full throughput (one digit per cycle) while out_ready=1.
- FSM states:
  - IDLE: not in a word.
  - CARRY: in a word; all digits so far were zero, so the +1 carry is still pending.
  - COMP: in a word; a nonzero digit has been seen, so remaining digits are plain complement.
- Per accepted digit x (with c = 1 in CARRY or on sop, else 0):
  - negate mode: y = (~x + c) mod 2^DIGIT_W.
  - pass mode: y = x.
  - Next state: eop -> IDLE; else (c==1 and x==0) -> CARRY; else -> COMP.
  - In pass mode, CARRY/COMP still track the word for framing; the values are unused.
- Digit arithmetic: DIGIT_W+1-bit sum; the carry-out bit is discarded (it is implied by x==0).
- sop handling: in_sop loads mode <= neg_en and treats the digit as the first of a new word from any state.
  - sop accepted while in CARRY/COMP: abort the old word (no out_eop is emitted for it), start the new word, and pulse err the next cycle.
- Orphan digit: a digit without sop accepted in IDLE is dropped (no output beat); err pulses the next cycle.
- sop & eop on the same digit: single-digit word; starts with c=1 and returns to IDLE.
- out_ovf: set with an eop beat iff mode=negate and msb(x)=1 and msb(y)=1 (input was most-negative, e.g. 0x80 for an 8-bit word); otherwise 0.
- neg_en changes mid-word are ignored.
- Word length is arbitrary (>= 1 digit); there is no internal length counter.

Decomposition:
- Shared package serial_arith_pkg: state enum (IDLE, CARRY, COMP) and mode localparams MODE_PASS=0, MODE_NEG=1.
- Natural sub-module: serial_digit_neg, combinational; inputs (x, c, mode); outputs (y, x_nonzero, msb flags).
- FSM, framing checks and the output register stay in the top-level module.

Test Plan (DIGIT_W=4 unless noted):
- Negate 0x0C: digits C(sop),0(eop), neg_en=1, out_ready=1 -> out digits 4,F (0xF4); out_sop on first, out_eop on second; ovf=0; each beat 1 cycle after its input.
- Overflow 0x80: digits 0(sop),8(eop), negate -> outputs 0,8; out_ovf=1 on the eop beat. Input 0x00 -> outputs 0,0 with ovf=0.
- Pass mode plus mode latch: 0x5A with neg_en=0 at sop, then neg_en=1 on the second digit -> outputs A,5 unchanged, ovf=0.
- Backpressure: hold out_ready=0 for 3 cycles mid-word -> in_ready=0, out_digit/out_valid stable, no digit lost; 0x0C still yields 4,F.
- Framing errors:
  - Digit 3 without sop in IDLE -> dropped, err pulse, no out_valid.
  - sop arriving during a word -> err pulse; the new word negates correctly from c=1.
- DIGIT_W=1 build, and reset mid-word:
  - Negating bits 0,0,1,1 LSB-first gives 0,0,1,0.
  - Assert areset mid-word -> out_valid=0 immediately; the next word is processed correctly.
